// File: rtl/shift_norm_if.sv
// shift_norm_if: start/busy/done handshake and data bus of the shift_norm
// normalizer. Building with SHIFT_NORM_SIGNED_EN adds the signed_mode request bit.
//
// Handshake: the master may raise start at any time with data (and
// signed_mode) stable alongside it. The request is accepted on a rising edge
// only while the slave is idle or showing done. While busy is high, start is
// ignored and is not queued. done is a one-cycle pulse. result, count and zero
// are valid from that pulse and hold their values until the next accepted
// start.
interface shift_norm_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 5
);
  logic             start;
  logic [WIDTH-1:0] data;
`ifdef SHIFT_NORM_SIGNED_EN
  logic             signed_mode;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    count;
  logic             zero;

`ifdef SHIFT_NORM_SIGNED_EN
  modport master (output start, data, signed_mode,
                  input  busy, done, result, count, zero);
  modport slave  (input  start, data, signed_mode,
                  output busy, done, result, count, zero);
`else
  modport master (output start, data,
                  input  busy, done, result, count, zero);
  modport slave  (input  start, data,
                  output busy, done, result, count, zero);
`endif
endinterface

// File: rtl/shift_norm.sv
// shift_norm: multi-cycle left normalizer. It resolves one binary stage per
// cycle (16, 8, 4, 2, 1) and reports the shift applied. That count is the
// right shift a later barrel shifter needs to restore the value.
// Optional macro SHIFT_NORM_SIGNED_EN adds signed_mode: in that mode the
// block strips redundant sign bits instead of leading zeros.
// o_dbg_state encoding: 0 = IDLE, 1 = RUN, 2 = DONE.
module shift_norm #(
  parameter int WIDTH = 32,
  parameter int CW    = 5
) (
  input  logic        clk,
  input  logic        rst,
  shift_norm_if.slave bus,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_stage;
  logic             r_zero;

  logic             w_accept;
  logic             w_busy;
  logic             w_done;
  logic             w_last;
  logic             w_signed;
  logic             w_take;
  logic [5:0]       w_keep;
  logic [WIDTH-1:0] w_cmp;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_work_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_zero_nxt;

`ifdef SHIFT_NORM_SIGNED_EN
  logic r_signed;

  // Capture the mode with the request; it stays fixed for the whole run.
  always_ff @(posedge clk) begin
    if (rst)           r_signed <= 1'b0;
    else if (w_accept) r_signed <= bus.signed_mode;
  end

  assign w_signed = r_signed;
`else
  assign w_signed = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and handshake outputs. A new request is taken in IDLE and in
  // DONE, so back-to-back operations lose no cycle.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_last   = (r_stage == CW'(1));
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Stage test. Unsigned mode shifts when the top k bits are all zero. Signed
  // mode shifts when the top k+1 bits all match the sign bit: XOR with the
  // sign turns that into a test for zeros. Both tests keep the bits above a
  // cut point and check that they are zero.
  always_comb begin
    w_cmp       = w_signed ? (r_work ^ {WIDTH{r_work[WIDTH-1]}}) : r_work;
    w_keep      = w_signed ? (6'(WIDTH - 1) - {1'b0, r_stage})
                           : (6'(WIDTH) - {1'b0, r_stage});
    w_take      = ((w_cmp >> w_keep) == '0);
    w_shifted   = r_work << r_stage;
    w_work_nxt  = w_take ? w_shifted : r_work;
    w_count_nxt = w_take ? (r_count + r_stage) : r_count;
    // A full count of 31 in signed mode only comes from 0 or all-ones input.
    // In unsigned mode an input of 1 also reaches 31, so test the word.
    w_zero_nxt  = w_signed ? (w_count_nxt == CW'(WIDTH - 1)) : (w_work_nxt == '0);
  end

  // Datapath: load on accept, apply one stage per RUN cycle, and publish
  // result/zero on the last stage. Outputs hold until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work   <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_stage  <= '0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_work  <= bus.data;
      r_count <= '0;
      r_stage <= CW'(WIDTH / 2);
    end else if (r_state == S_RUN) begin
      r_work  <= w_work_nxt;
      r_count <= w_count_nxt;
      r_stage <= r_stage >> 1;
      if (w_last) begin
        r_result <= w_work_nxt;
        r_zero   <= w_zero_nxt;
      end
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.result  = r_result;
  assign bus.count   = r_count;
  assign bus.zero    = r_zero;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_norm.sv
// tb_shift_norm: directed and random stimulus for shift_norm. Every result is
// checked against a leading-bit-count model.
// Define SHIFT_NORM_SIGNED_EN to also exercise signed_mode.
module tb_shift_norm;

  localparam int W  = 32;
  localparam int CW = 5;
  localparam int EW = W + CW + 1;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp;

  shift_norm_if #(.WIDTH(W), .CW(CW)) bus ();

  shift_norm #(.WIDTH(W), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count the leading zeros (unsigned) or the redundant sign bits
  // (signed), then cap the count at 31.
  function automatic logic [EW-1:0] model(input logic [W-1:0] d, input logic s);
    int n;
    logic z;
    n = 0;
    if (s) begin
      for (int i = W - 1; i >= 0; i--) begin
        if (d[i] != d[W-1]) break;
        n++;
      end
      n = n - 1;
      z = (d == '0) || (d == '1);
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (d[i]) break;
        n++;
      end
      z = (d == '0);
    end
    if (n > W - 1) n = W - 1;
    return {d << n, CW'(n), z};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request and follow it to done. The task returns #1 after the
  // done edge, so a call made straight after it lands in the done cycle and
  // tests a back-to-back request. With poke set, a second start is driven
  // during RUN; the DUT must ignore it.
  task automatic run_op(input logic [W-1:0] d, input logic s, input bit poke);
    int n;
    logic [EW-1:0] e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.data  = d;
`ifdef SHIFT_NORM_SIGNED_EN
    bus.signed_mode = s;
`endif
    exp_q.push_back(model(d, s));
    @(posedge clk); #1;
    check("busy_after_accept", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    forever begin
      @(posedge clk); #1;
      n++;
      if (bus.done) break;
      check("busy_during_run", 64'(bus.busy), 64'd1);
      if (n > 20) break;
      if (poke && n == 2) begin
        @(negedge clk);
        bus.start = 1'b1;
        bus.data  = 32'h0000_0001;
      end
      if (poke && n == 3) begin
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    check("latency_edges", 64'(n + 1), 64'd6);
    check("busy_at_done", 64'(bus.busy), 64'd0);
    e = exp_q.pop_front();
    last_exp = e;
    check("result", 64'(bus.result), 64'(e[EW-1 -: W]));
    check("count",  64'(bus.count),  64'(e[CW:1]));
    check("zero",   64'(bus.zero),   64'(e[0]));
  endtask

  initial begin
    int done_seen;
    logic [W-1:0] r;
    bus.start = 1'b0;
    bus.data  = '0;
`ifdef SHIFT_NORM_SIGNED_EN
    bus.signed_mode = 1'b0;
`endif
    last_exp = '0;

    // Reset for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   64'(bus.busy),   64'd0);
    check("rst_done",   64'(bus.done),   64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_count",  64'(bus.count),  64'd0);
    check("rst_zero",   64'(bus.zero),   64'd0);
    check("rst_state",  64'(dbg_state),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values, including an all-zero input followed by a
    // back-to-back request.
    run_op(32'h0000_00ff, 1'b0, 1'b0);
    run_op(32'h8000_0000, 1'b0, 1'b0);
    run_op(32'h0001_0000, 1'b0, 1'b0);
    run_op(32'h0000_0000, 1'b0, 1'b0);
    run_op(32'h0000_0001, 1'b0, 1'b0);

    // A start raised during RUN is ignored.
    run_op(32'h0000_00ff, 1'b0, 1'b1);

    // Idle hold: outputs keep their values and done stays low.
    done_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    check("idle_no_done", 64'(done_seen), 64'd0);
    check("idle_state",   64'(dbg_state), 64'd0);
    check("idle_result",  64'(bus.result), 64'(last_exp[EW-1 -: W]));
    check("idle_count",   64'(bus.count),  64'(last_exp[CW:1]));
    run_op(32'h0000_0f00, 1'b0, 1'b0);

    // Reset asserted in the middle of a run.
    @(negedge clk);
    bus.start = 1'b1;
    bus.data  = 32'h0000_0003;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy",   64'(bus.busy),   64'd0);
    check("midrst_done",   64'(bus.done),   64'd0);
    check("midrst_result", 64'(bus.result), 64'd0);
    check("midrst_count",  64'(bus.count),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);

`ifdef SHIFT_NORM_SIGNED_EN
    // Signed mode: redundant sign bits.
    run_op(32'hffff_0000, 1'b1, 1'b0);
    run_op(32'hffff_ffff, 1'b1, 1'b0);
    run_op(32'h00ff_0000, 1'b1, 1'b0);
    run_op(32'h0000_0000, 1'b1, 1'b0);
    run_op(32'hffff_ffff, 1'b0, 1'b0);
`endif

    // Random words with varied leading runs.
    for (int i = 0; i < 30; i++) begin
      r = $urandom();
      r = r >> $urandom_range(0, 31);
`ifdef SHIFT_NORM_SIGNED_EN
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) r = ~r;
        run_op(r, 1'b1, 1'b0);
      end else begin
        run_op(r, 1'b0, 1'b0);
      end
`else
      run_op(r, 1'b0, 1'b0);
`endif
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
